// File: rtl/main_fsm_pkg.sv
// Shared types and encodings for the multicycle RISC-V control FSM.
// Optional JAL support is enabled with the MAIN_FSM_JAL_EN macro.
package main_fsm_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
`ifdef MAIN_FSM_JAL_EN
    BEQ      = 4'd9,
    JAL      = 4'd10
`else
    BEQ      = 4'd9
`endif
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
`ifdef MAIN_FSM_JAL_EN
  localparam logic [1:0] RES_PC4    = 2'b10;
`endif

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] F_ADD = 3'b000;
  localparam logic [2:0] F_XOR = 3'b100;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       alud;
    logic [2:0] alu_f;
  } ctrl_t;

endpackage

// File: rtl/main_fsm_out.sv
// Moore output decode: control bundle from the current state.
// JAL outputs exist only when MAIN_FSM_JAL_EN is defined.
module main_fsm_out
  import main_fsm_pkg::*;
(
  input  state_t     state,
  input  logic [2:0] funct3,
  input  logic       zero,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl       = '0;
    ctrl.alu_f = F_ADD;
    unique case (state)
      FETCH: begin
        ctrl.pc_write  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_FOUR;
      end
      DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
      end
      MEMADR: begin
        ctrl.alu_src_a = SRCA_RD1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      MEMREAD: ctrl.adr_src = 1'b1;
      MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_DATA;
      end
      MEMWRITE: begin
        ctrl.adr_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      EXECR: begin
        ctrl.alu_src_a = SRCA_RD1;
        ctrl.alu_src_b = SRCB_RD2;
        ctrl.alud      = 1'b1;
        ctrl.alu_f     = funct3;
      end
      EXECI: begin
        ctrl.alu_src_a = SRCA_RD1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alud      = 1'b1;
        ctrl.alu_f     = funct3;
      end
      ALUWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      BEQ: begin
        ctrl.alu_src_a = SRCA_RD1;
        ctrl.alu_src_b = SRCB_RD2;
        ctrl.alud      = 1'b1;
        ctrl.alu_f     = F_XOR;
        ctrl.pc_write  = zero;
      end
`ifdef MAIN_FSM_JAL_EN
      JAL: begin
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.pc_write   = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_PC4;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/main_fsm.sv
// Multicycle RISC-V main control FSM (state register + next state).
// Define MAIN_FSM_JAL_EN to support the JAL opcode.
module main_fsm
  import main_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       adr_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic       alud,
  output logic [2:0] alu_f,
  output logic       ill_op
);

  state_t state_q, state_d;
  logic   ill_dec;
  ctrl_t  ctrl;
  logic   fetch_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ill_dec = 1'b0;
    unique case (state_q)
      FETCH: if (mem_ready) state_d = DECODE;
      DECODE: begin
        unique case (op)
          OP_LOAD,
          OP_STORE: state_d = MEMADR;
          OP_RTYPE: state_d = EXECR;
          OP_ITYPE: state_d = EXECI;
          OP_BEQ:   state_d = BEQ;
`ifdef MAIN_FSM_JAL_EN
          OP_JAL:   state_d = JAL;
`else
          OP_JAL: begin
            state_d = FETCH;
            ill_dec = 1'b1;
          end
`endif
          default: begin
            state_d = FETCH;
            ill_dec = 1'b1;
          end
        endcase
      end
      MEMADR:
        state_d = (op == OP_STORE) ? MEMWRITE : MEMREAD;
      MEMREAD:  if (mem_ready) state_d = MEMWB;
      MEMWRITE: if (mem_ready) state_d = FETCH;
      EXECR,
      EXECI:    state_d = ALUWB;
      default:  state_d = FETCH;
    endcase
  end

  main_fsm_out u_out (
    .state  (state_q),
    .funct3 (funct3),
    .zero   (zero),
    .ctrl   (ctrl)
  );

  // Fetch strobes only fire once memory hands back the instruction.
  assign fetch_ok   = (state_q != FETCH) | mem_ready;
  assign pc_write   = rst_n & ctrl.pc_write & fetch_ok;
  assign ir_write   = rst_n & ctrl.ir_write & fetch_ok;
  assign mem_write  = rst_n & ctrl.mem_write;
  assign reg_write  = rst_n & ctrl.reg_write;
  assign ill_op     = rst_n & ill_dec;
  assign adr_src    = ctrl.adr_src;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign result_src = ctrl.result_src;
  assign alud       = ctrl.alud;
  assign alu_f      = ctrl.alu_f;

endmodule

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The port clk SHALL be an input, 1 bit wide, and be the single system clock; all state changes occur on its rising edge.
REQ-003 The port rst_n SHALL be an input, 1 bit wide, and be the reset; it is asynchronous and active-low.
REQ-004 The port op SHALL be an input, 7 bits wide, carrying the instruction opcode field, bits [6:0] of the instruction register.
REQ-005 The port funct3 SHALL be an input, 3 bits wide, carrying the instruction funct3 field, bits [14:12].
REQ-006 The port zero SHALL be an input, 1 bit wide, carrying the ALU result==0 flag.
REQ-007 The port mem_ready SHALL be an input, 1 bit wide, and be high when memory completes the current access.
REQ-008 The outputs pc_write, ir_write, mem_write and reg_write SHALL each be 1 bit wide and be the register and memory write enables.
REQ-009 The output adr_src SHALL be 1 bit wide: 0 selects the PC as the memory address, 1 selects the ALU result.
REQ-010 The outputs alu_src_a, alu_src_b and result_src SHALL each be 2 bits wide and be the datapath mux selects.
REQ-011 The output alud SHALL be 1 bit wide and the output alu_f SHALL be 3 bits wide; together they drive the downstream ALU decoder inputs (ALUD, F).
REQ-012 The output ill_op SHALL be 1 bit wide and pulse for one cycle when an unsupported opcode is decoded.

Function
REQ-013 The block SHALL be a Moore FSM with the states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ and JAL.
REQ-014 In FETCH, the FSM SHALL assert ir_write=1, pc_write=1 and alu_src_b=10 (constant 4), and SHALL stay in FETCH until mem_ready=1; pc_write and ir_write are asserted only in the mem_ready cycle.
REQ-015 In DECODE, the FSM SHALL branch on op as follows: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; 1101111 -> JAL; any other value -> FETCH with ill_op=1 for that cycle.
REQ-016 From MEMADR, the FSM SHALL go to MEMREAD for load or MEMWRITE for store.
REQ-017 MEMREAD SHALL set adr_src=1 and wait for mem_ready, then go to MEMWB.
REQ-018 MEMWRITE SHALL set adr_src=1 and mem_write=1, wait for mem_ready, then go to FETCH.
REQ-019 MEMWB SHALL set reg_write=1 and result_src=01, then go to FETCH.
REQ-020 EXECR and EXECI SHALL set alud=1 and alu_f=funct3, then go to ALUWB.
REQ-021 ALUWB SHALL set reg_write=1 and result_src=00, then go to FETCH.
REQ-022 BEQ SHALL set alud=1 and alu_f=100 (XOR compare) with pc_write=zero, then go to FETCH.
REQ-023 JAL SHALL set pc_write=1, reg_write=1 and result_src=10 (PC+4), then go to FETCH.
REQ-024 In every state not listed above, the FSM SHALL drive alud=0 and alu_f=000 (ADD).
REQ-025 The FSM SHALL keep mem_write held high continuously while MEMWRITE waits for mem_ready.
REQ-026 The block SHALL implement a one-cycle latency per state, so that an R-type instruction takes 4 cycles and a load takes 5 cycles when mem_ready is constantly 1.

Reset
REQ-027 Asserting rst_n low SHALL force the state to FETCH immediately, independent of clk.
REQ-028 While rst_n is low, all write enables and ill_op SHALL be 0.
REQ-029 Asserting reset mid-MEMWRITE SHALL drop mem_write in the same time step.
REQ-030 On rst_n release, the first rising edge of clk SHALL evaluate FETCH normally.

Configuration
REQ-031 When the macro MAIN_FSM_JAL_EN is defined, the JAL state and opcode 1101111 SHALL be supported.
REQ-032 When MAIN_FSM_JAL_EN is undefined, the JAL state SHALL be absent and opcode 1101111 SHALL be treated as illegal: ill_op=1 and the FSM returns to FETCH.

Structure
REQ-033 The shared package SHALL hold the state encoding enum, the opcode constants and the result_src and alu_src encodings.
REQ-034 The output decode SHALL be implemented in one sub-module, main_fsm_out, a pure function of the state and of funct3 and zero.

Verification
REQ-035 The bench SHALL apply rst_n low mid-MEMWRITE and check that state=FETCH and mem_write=0 without a clock edge.
REQ-036 The bench SHALL issue R-type op=0110011 with funct3=101 and mem_ready=1, and check the sequence FETCH,DECODE,EXECR,ALUWB with alud=1 and alu_f=101 in EXECR.
REQ-037 The bench SHALL issue a load with mem_ready held 0 for 3 cycles in MEMREAD, and check that the FSM holds MEMREAD for 4 cycles and then asserts reg_write in MEMWB.
REQ-038 The bench SHALL issue BEQ with zero=1 and check pc_write=1 and alu_f=100; with zero=0 it SHALL check pc_write=0.
REQ-039 The bench SHALL issue op=1111111 and check ill_op=1 for exactly 1 cycle followed by a return to FETCH.
REQ-040 The bench SHALL issue op=1101111 with MAIN_FSM_JAL_EN defined and check that JAL asserts pc_write, reg_write and result_src=10; without the macro it SHALL check ill_op=1.
